// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the core-side store buffer.
// Entries hold a word index plus data; byte offsets never reach the buffer.
package sb_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_AW            = 32;

    typedef struct packed {
        logic              valid;
        logic [SB_AW-3:0]  word;
        logic [31:0]       data;
    } sb_entry_t;

    function automatic int unsigned ptr_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr + 32'd1 == depth) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/store_buffer_fwd.sv
// Youngest-match store-to-load forwarding over the buffered entries.
// Scans oldest to youngest so the last hit (nearest tail-1) wins.
module sb_fwd
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW
) (
    input  sb_entry_t [DEPTH-1:0]         entries,
    input  logic [$clog2(DEPTH)-1:0]      tail,
    input  logic [AW-3:0]                 word,
    output logic                          hit,
    output logic [31:0]                   data
);

    localparam int PW = $clog2(DEPTH);

    always_comb begin
        logic [PW-1:0] idx;
        idx  = '0;
        hit  = 1'b0;
        data = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PW'(k);
            if (entries[idx].valid &&
                entries[idx].word[AW-3:0] == word) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: single-cycle store retirement into a FIFO that drains
// to memory over valid/ready, with combinational load forwarding.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          stall,
    output logic [AW-1:0] mem_rd_adr,
    input  logic [31:0]   mem_rd_data,
    output logic          wr_valid,
    output logic [AW-1:0] wr_adr,
    output logic [31:0]   wr_data,
    input  logic          wr_ready,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [PW:0]            count_q, count_d;
    sb_entry_t [DEPTH-1:0]  entries_q, entries_d;

    logic       full;
    logic       enq;
    logic       deq;
    logic       fwd_hit;
    logic [31:0] fwd_data;
    sb_entry_t  head_entry;
    logic       unused_offset;

    assign full       = (count_q == (PW+1)'(DEPTH));
    assign stall      = memwrite && full;
    assign enq        = memwrite && !full;
    assign wr_valid   = (count_q != '0);
    assign deq        = wr_valid && wr_ready;
    assign empty      = (count_q == '0);
    assign head_entry = entries_q[head_q];
    assign wr_adr     = {head_entry.word[AW-3:0], 2'b00};
    assign wr_data    = head_entry.data;
    assign mem_rd_adr = {dataadr[AW-1:2], 2'b00};
    assign readdata   = fwd_hit ? fwd_data : mem_rd_data;

    // Word-only accesses: the byte offset is intentionally dropped.
    assign unused_offset = ^dataadr[1:0];

    sb_fwd #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd (
        .entries (entries_q),
        .tail    (tail_q),
        .word    (dataadr[AW-1:2]),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (deq) begin
            entries_d[head_q].valid = 1'b0;
            head_d = PW'(ptr_inc(32'(head_q), DEPTH));
        end

        // Enqueue never targets the head slot being drained: full blocks it.
        if (enq) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].word  = (SB_AW-2)'(dataadr[AW-1:2]);
            entries_d[tail_q].data  = writedata;
            tail_d = PW'(ptr_inc(32'(tail_q), DEPTH));
        end

        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            entries_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a write/load scoreboard.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic [31:0] mem_rd_adr;
    logic [31:0] mem_rd_data;
    logic        wr_valid;
    logic [31:0] wr_adr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        empty;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .readdata    (readdata),
        .stall       (stall),
        .mem_rd_adr  (mem_rd_adr),
        .mem_rd_data (mem_rd_data),
        .wr_valid    (wr_valid),
        .wr_adr      (wr_adr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .empty       (empty)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    logic        ld_req;
    int          checks = 0;
    int          errors = 0;
    wr_t         mon_w;
    logic [31:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: loads requested this cycle and memory write handshakes.
    always @(negedge clk) begin
        if (!reset && ld_req) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load_queue: got empty queue expected entry");
            end else begin
                mon_e = rq.pop_front();
                chk("readdata", readdata, mon_e);
            end
        end
        if (!reset && wr_valid && wr_ready) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got adr 0x%08h data 0x%08h expected none",
                         wr_adr, wr_data);
            end else begin
                mon_w = wq.pop_front();
                chk("wr_adr", wr_adr, mon_w.adr);
                chk("wr_data", wr_data, mon_w.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ld_req   = 1'b0;
        memwrite = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input bit push);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        if (push) wq.push_back('{adr: {a[31:2], 2'b00}, data: d});
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        dataadr = a;
        ld_req  = 1'b1;
        rq.push_back(exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        memwrite    = 1'b0;
        dataadr     = '0;
        writedata   = '0;
        mem_rd_data = 32'hCAFEF00D;
        wr_ready    = 1'b0;
        ld_req      = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and a miss load
        tick();
        load(32'h20, 32'hCAFEF00D);
        @(negedge clk);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("mem_rd_adr", mem_rd_adr, 32'h20);

        // Single store, not visible same cycle, forwarded next cycle
        tick();
        store(32'h10, 32'h11111111, 1);
        ld_req = 1'b1;
        rq.push_back(32'hCAFEF00D);
        tick();
        load(32'h10, 32'h11111111);
        @(negedge clk);
        chk("t2_wr_valid", {31'd0, wr_valid}, 32'd1);
        chk("t2_wr_adr_out", wr_adr, 32'h10);
        chk("t2_empty", {31'd0, empty}, 32'd0);
        tick();
        wr_ready = 1'b1;
        load(32'h10, 32'h11111111);
        tick();
        wr_ready = 1'b0;
        load(32'h10, 32'hCAFEF00D);
        @(negedge clk);
        chk("t2_drained", {31'd0, empty}, 32'd1);

        // Youngest match wins, offset ignored, drain in order
        tick();
        store(32'h10, 32'hA, 1);
        tick();
        store(32'h10, 32'hB, 1);
        tick();
        load(32'h13, 32'hB);
        @(negedge clk);
        chk("t3_mem_rd_adr", mem_rd_adr, 32'h10);
        tick();
        wr_ready = 1'b1;
        tick();
        tick();
        wr_ready = 1'b0;
        @(negedge clk);
        chk("t3_empty", {31'd0, empty}, 32'd1);

        // Fill, stall on the 5th, drain does not unblock same cycle
        for (int i = 0; i < 4; i++) begin
            tick();
            store(32'h100 + 32'(4 * i), 32'hD0 + 32'(i), 1);
            @(negedge clk);
            chk("t4_fill_stall", {31'd0, stall}, 32'd0);
        end
        tick();
        store(32'h110, 32'hD4, 1);
        @(negedge clk);
        chk("t4_full_stall", {31'd0, stall}, 32'd1);
        tick();
        store(32'h110, 32'hD4, 0);
        wr_ready = 1'b1;
        @(negedge clk);
        chk("t4_drain_stall", {31'd0, stall}, 32'd1);
        tick();
        store(32'h110, 32'hD4, 0);
        wr_ready = 1'b0;
        @(negedge clk);
        chk("t4_accept_stall", {31'd0, stall}, 32'd0);
        tick();
        store(32'h114, 32'hDEAD, 0);
        @(negedge clk);
        chk("t4_refull_stall", {31'd0, stall}, 32'd1);
        tick();
        load(32'h110, 32'hD4);
        @(negedge clk);
        chk("t4_head_adr", wr_adr, 32'h104);
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_ready = 1'b1;
        end
        tick();
        wr_ready = 1'b0;
        @(negedge clk);
        chk("t4_empty", {31'd0, empty}, 32'd1);

        // Streaming with continuous ready, pointers wrap
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            store(32'h200 + 32'(4 * i), 32'h5000 + 32'(i), 1);
            @(negedge clk);
            chk("t5_stall", {31'd0, stall}, 32'd0);
            if (i > 0) chk("t5_wr_valid", {31'd0, wr_valid}, 32'd1);
        end
        tick();
        tick();
        wr_ready = 1'b0;
        @(negedge clk);
        chk("t5_empty", {31'd0, empty}, 32'd1);

        // Reset discards pending stores
        for (int i = 0; i < 3; i++) begin
            tick();
            store(32'h300 + 32'(4 * i), 32'h7000 + 32'(i), 0);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("t6_empty", {31'd0, empty}, 32'd1);
        tick();
        wr_ready = 1'b1;
        load(32'h300, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) tick();
        wr_ready = 1'b0;
        @(negedge clk);
        chk("t6_still_empty", {31'd0, empty}, 32'd1);

        tick();
        chk("wq_left", 32'(wq.size()), 32'd0);
        chk("rq_left", 32'(rq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write buffer between the single-cycle core's data port (memwrite/dataadr/writedata/readdata) and the data memory.
- Store instructions retire into a small FIFO in one cycle. The FIFO drains to memory over a valid/ready write port, so memory write latency is hidden from the core.
- Loads are served combinationally: from the youngest matching buffered store, otherwise from the memory read port.
- The core is stalled only when a store arrives while the buffer is full.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2).
- AW, 32, byte-address width; word index is AW-2 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- memwrite  in  1  core store request this cycle
- dataadr  in  AW  core byte address (load and store)
- writedata  in  32  core store data
- readdata  out  32  load data to core
- stall  out  1  core must hold PC/state this cycle
- mem_rd_adr  out  AW  memory read address (word-aligned dataadr)
- mem_rd_data  in  32  memory combinational read data
- wr_valid  out  1  buffered store presented to memory
- wr_adr  out  AW  head entry address (word-aligned)
- wr_data  out  32  head entry data
- wr_ready  in  1  memory accepts head entry this cycle
- empty  out  1  no pending stores (fence/flush indication)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: count=0, head=0, tail=0, all entry valid bits 0, wr_valid=0, empty=1, stall=0. Entry addr/data are don't-care.
- State: circular FIFO with head/tail pointers of log2(DEPTH) bits and count of log2(DEPTH)+1 bits. Pointers wrap DEPTH-1→0. full = (count==DEPTH).
- Enqueue: memwrite && !full. At the clock edge, entry[tail] ← {dataadr[AW-1:2], writedata}; tail+1.
- Stall: stall = memwrite && full (combinational). No enqueue occurs that cycle, and the core re-presents the store. A drain in the same cycle does not unblock it; the store is accepted the following cycle.
- Drain: wr_valid = (count≠0). wr_adr = {entry[head].word, 2'b00}; wr_data = entry[head].data. On wr_valid && wr_ready: head+1 and the entry is invalidated.
- Simultaneous enqueue and drain: count unchanged; both pointers advance.
- Forwarding:
  - Compare dataadr[AW-1:2] against every valid entry.
  - If one or more match, readdata = data of the youngest match, i.e. the match nearest tail-1 going backward.
  - If none match, readdata = mem_rd_data.
  - mem_rd_adr = {dataadr[AW-1:2], 2'b00} always.
  - Byte offset dataadr[1:0] is ignored (word accesses only).
- A store enqueued this cycle is not visible to forwarding until the next cycle.
- An entry being drained this cycle still forwards this cycle.
- Memory must not assert wr_ready when wr_valid=0; the block ignores it.
- empty = (count==0), registered-state derived, no combinational input path.
- Reset mid-operation discards all pending stores; they are never written. wr_valid is 0 from the cycle after reset is sampled.
- Latency: store accept→wr_valid visible = 1 cycle when empty. Load path: 0 cycles.

Decomposition:
- Package sb_pkg:
  - typedef sb_entry_t {logic valid; logic [AW-3:0] word; logic [31:0] data;}
  - constant SB_DEPTH_DEFAULT=4
  - function ptr_inc (wrap).
- Sub-module sb_fwd: combinational youngest-match priority select over DEPTH entries, given tail. Inputs: entries, tail, lookup word. Outputs: hit, data.

Test Plan:
- Reset, no stores → empty=1, wr_valid=0, stall=0; load 0x20 returns mem_rd_data (drive 0xCAFEF00D).
- Store 0x10←0x11111111 with wr_ready=0, next cycle load 0x10 → readdata=0x11111111, wr_valid=1, wr_adr=0x10.
- Stores 0x10←0xA, then 0x10←0xB, load 0x13 → readdata=0xB (youngest wins, offset ignored). Drain order wr_data 0xA then 0xB.
- wr_ready=0, 4 stores then a 5th → stall=1 on the 5th with no enqueue. Raise wr_ready one cycle → the 5th is accepted the next cycle and count stays 4.
- wr_ready=1 continuous, a store every cycle for 10 cycles → stall never asserts, count ≤1, pointers wrap, all 10 addresses written in order.
- 3 stores pending, assert reset one cycle → wr_valid=0 and empty=1 next cycle; no further memory writes.
